// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman encoder sequencer: state encodings,
// default watchdog limit and small helpers over the stage chain.
package huff_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CNT  = 3'd1;
    localparam logic [2:0] S_SORT = 3'd2;
    localparam logic [2:0] S_TREE = 3'd3;
    localparam logic [2:0] S_CODE = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;
    localparam logic [2:0] S_ERR  = 3'd7;

    localparam int TIMEOUT_DEFAULT = 1023;

    typedef enum logic [2:0] {
        IDLE = S_IDLE,
        CNT  = S_CNT,
        SORT = S_SORT,
        TREE = S_TREE,
        CODE = S_CODE,
        OUT  = S_OUT,
        FIN  = S_FIN,
        ERR  = S_ERR
    } state_e;

    function automatic logic is_stage(input state_e s);
        return (s inside {CNT, SORT, TREE, CODE, OUT});
    endfunction

    // The fixed order in which the encoder stages run.
    function automatic state_e next_stage(input state_e s);
        case (s)
            CNT:     return SORT;
            SORT:    return TREE;
            TREE:    return CODE;
            CODE:    return OUT;
            OUT:     return FIN;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/huff_stage_timer.sv
// Per-stage watchdog: restarts at 0 on stage entry, counts while a stage runs,
// and flags expiry in the cycle the count equals TIMEOUT.
module huff_stage_timer #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic Clk_in,
    input  logic n_Rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clk_in) begin
        if (!n_Rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/huff_seq_ctrl.sv
// Top-level sequencer: launches the five encoder stages in turn, guards each
// with a watchdog, and reports busy/done/error/frame count to the host.
module huff_seq_ctrl
    import huff_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 10,
    parameter int FRM_W   = 8
) (
    input  logic             Clk_in,
    input  logic             n_Rst,
    input  logic             Start,
    input  logic             Abort,
    input  logic             Done_cnt,
    input  logic             Done_sort,
    input  logic             Done_tree,
    input  logic             Done_code,
    input  logic             Done_out,
    output logic             Start_cnt,
    output logic             Start_sort,
    output logic             Start_tree,
    output logic             Start_code,
    output logic             Start_out,
    output logic             Busy,
    output logic             Frame_done,
    output logic             Err,
    output logic [2:0]       Err_stage,
    output logic [2:0]       state,
    output logic [FRM_W-1:0] Frame_cnt
);

    state_e           cur_state;
    state_e           nxt_state;
    logic             start_q;
    logic             start_hold;
    logic             start_edge;
    logic             accept;
    logic             stage_done;
    logic             timer_clear;
    logic             timer_enable;
    logic             timer_expired;
    logic             entry_q;
    logic             err_q;
    logic [2:0]       err_stage_q;
    logic [FRM_W-1:0] frame_cnt_q;

    // start_hold masks a Start level that was already high across reset until it drops.
    assign start_edge = Start && !start_q && !start_hold;
    assign accept     = start_edge && !Abort && (cur_state == IDLE || cur_state == ERR);

    always_comb begin
        stage_done = 1'b0;
        case (cur_state)
            CNT:     stage_done = Done_cnt;
            SORT:    stage_done = Done_sort;
            TREE:    stage_done = Done_tree;
            CODE:    stage_done = Done_code;
            OUT:     stage_done = Done_out;
            default: stage_done = 1'b0;
        endcase
    end

    // Abort outranks everything; within a stage, Done outranks the watchdog.
    always_comb begin
        nxt_state = cur_state;
        if (cur_state != IDLE && Abort) begin
            nxt_state = IDLE;
        end else if (is_stage(cur_state)) begin
            if (stage_done) begin
                nxt_state = next_stage(cur_state);
            end else if (timer_expired) begin
                nxt_state = ERR;
            end
        end else if (cur_state == FIN) begin
            nxt_state = IDLE;
        end else if (accept) begin
            nxt_state = CNT;
        end
    end

    assign timer_enable = is_stage(cur_state);
    assign timer_clear  = is_stage(nxt_state) && (nxt_state != cur_state);

    huff_stage_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .Clk_in  (Clk_in),
        .n_Rst   (n_Rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge Clk_in) begin
        if (!n_Rst) begin
            cur_state   <= IDLE;
            start_q     <= 1'b0;
            start_hold  <= Start;
            entry_q     <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= 3'd0;
            frame_cnt_q <= '0;
        end else begin
            cur_state  <= nxt_state;
            start_q    <= Start;
            start_hold <= start_hold && Start;
            entry_q    <= timer_clear;
            if (nxt_state == ERR && cur_state != ERR) begin
                err_q       <= 1'b1;
                err_stage_q <= cur_state;
            end else if (accept) begin
                err_q       <= 1'b0;
                err_stage_q <= 3'd0;
            end
            if (nxt_state == FIN && cur_state != FIN) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    // entry_q marks the first cycle in a stage, so each launch is a single pulse.
    assign Start_cnt  = entry_q && (cur_state == CNT);
    assign Start_sort = entry_q && (cur_state == SORT);
    assign Start_tree = entry_q && (cur_state == TREE);
    assign Start_code = entry_q && (cur_state == CODE);
    assign Start_out  = entry_q && (cur_state == OUT);

    assign Busy       = (cur_state != IDLE) && (cur_state != ERR);
    assign Frame_done = (cur_state == FIN);
    assign Err        = err_q;
    assign Err_stage  = err_stage_q;
    assign state      = cur_state;
    assign Frame_cnt  = frame_cnt_q;

endmodule
